// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arbiter_pkg
//  Description : Shared definitions for the round-robin mux arbiter: requester
//                count, select width, FSM state encoding, and the rotating
//                priority search / one-hot decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set request index when scanning start, start+1, ... (mod N_REQ).
    // Returns start when nothing is set; callers only use it when req != 0.
    function automatic logic [SEL_W-1:0] next_owner(input logic [N_REQ-1:0] req,
                                                    input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] idx;
        logic             found;
        next_owner = start;
        found      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (!found && req[idx]) begin
                next_owner = idx;
                found      = 1'b1;
            end
        end
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_multiplexer.sv
`default_nettype none
// ============================================================================
//  Module      : multiplexer
//  Description : Plain 4:1 single-bit multiplexer, y = I[S].
//  Ports       : I [3:0] data in, S [1:0] select, y selected bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplexer
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] I,
    input  logic [SEL_W-1:0] S,
    output logic             y
);

    assign y = I[S];

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arbiter
//  Description : Round-robin scheduler sharing one 4:1 mux between four
//                requesters. Grants one owner at a time, drives the mux select
//                to the owner index, and bounds ownership with a hold counter
//                while other requests are pending.
//  Ports       : clk, rst_n (async active-low), req[3:0], I[3:0],
//                grant[3:0] (one-hot, registered), S[1:0] (registered),
//                busy, y = busy & I[S].
//  Options     : ARB_LOCK_EN - adds input 'lock'; while the owner keeps its
//                request and lock is high, hold expiry is suppressed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] I,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] S,
    output logic             busy,
    output logic             y
);

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [SEL_W-1:0] r_sel;
    logic             r_busy;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_hold;

    logic [SEL_W-1:0] w_sel_inc;
    logic [SEL_W-1:0] w_first;
    logic [SEL_W-1:0] w_after;
    logic             w_others;
    logic             w_lock;
    logic             w_y_raw;

    assign w_sel_inc = r_sel + 2'd1;
    assign w_first   = next_owner(req, r_ptr);
    // Scanning from owner+1 reaches every other requester before the owner,
    // so this picks the successor for both release and preemption.
    assign w_after   = next_owner(req, w_sel_inc);
    assign w_others  = |(req & ~r_grant);

`ifdef ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant <= onehot(w_first);
                        r_sel   <= w_first;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[r_sel]) begin
                        r_ptr <= w_sel_inc;
                        if (w_others) begin
                            r_grant <= onehot(w_after);
                            r_sel   <= w_after;
                            r_hold  <= '0;
                        end else begin
                            // S deliberately keeps the last owner index.
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_hold  <= '0;
                            r_state <= IDLE;
                        end
                    end else if (r_hold == c_HOLD_LAST) begin
                        if (w_lock) begin
                            r_hold <= c_HOLD_LAST;
                        end else if (w_others) begin
                            r_grant <= onehot(w_after);
                            r_sel   <= w_after;
                            r_ptr   <= w_sel_inc;
                            r_hold  <= '0;
                        end else begin
                            r_hold <= '0;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    multiplexer u_mux (
        .I (I),
        .S (r_sel),
        .y (w_y_raw)
    );

    assign grant = r_grant;
    assign S     = r_sel;
    assign busy  = r_busy;
    assign y     = r_busy & w_y_raw;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_arbiter
//  Description : Directed self-checking bench for mux_rr_arbiter. Expected
//                {grant,S,busy,y} tuples are queued when stimulus is applied
//                and popped when the DUT outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       y;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] grant;
    logic [1:0] S;
    logic       busy;
    logic       y;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif

    int   checks;
    int   errors;
    exp_t sbq[$];

    mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .req   (req),
        .I     (din),
        .grant (grant),
        .S     (S),
        .busy  (busy),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_owner(input int k);
        exp_t e;
        e.g = 4'b0001 << k;
        e.s = 2'(k);
        e.b = 1'b1;
        e.y = din[k];
        sbq.push_back(e);
    endtask

    task automatic push_idle(input logic [1:0] s);
        exp_t e;
        e.g = 4'b0000;
        e.s = s;
        e.b = 1'b0;
        e.y = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        exp_t o;
        o = {grant, S, busy, y};
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, observed=%h", tag, o);
        end else begin
            e = sbq.pop_front();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed grant=%b S=%0d busy=%b y=%b expected grant=%b S=%0d busy=%b y=%b",
                       tag, o.g, o.s, o.b, o.y, e.g, e.s, e.b, e.y);
            end
        end
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req    = 4'b0000;
        din    = 4'b0000;
        rst_n  = 1'b0;
`ifdef ARB_LOCK_EN
        lock   = 1'b0;
`endif

        // Reset and idle
        #2;
        push_idle(2'd0);
        check("reset_async");
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            push_idle(2'd0);
            check("idle");
        end

        // Single request, then release
        din = 4'b1001;
        req = 4'b0100;
        tick();
        push_owner(2);
        check("single_grant");
        din = 4'b1101;
        #1;
        push_owner(2);
        check("single_y_follow");
        req = 4'b0000;
        tick();
        push_idle(2'd2);
        check("single_release");

        // Round-robin fairness with all requesting
        do_reset();
        din = 4'b1010;
        req = 4'b1111;
        tick();
        push_owner(0);
        check("rr_first");
        for (int k = 0; k < 4; k++) begin
            tick();
            push_owner(k);
            check("rr_hold");
            req[k] = 1'b0;
            tick();
            push_owner((k + 1) % 4);
            check("rr_handoff");
            req[k] = 1'b1;
        end
        req = 4'b0000;
        tick();
        push_idle(2'd0);
        check("rr_idle");

        // Hold expiry alternation, then sole requester held
        do_reset();
        din = 4'b0010;
        req = 4'b0011;
        for (int c = 0; c < 24; c++) begin
            tick();
            push_owner((c / 8) % 2);
            check("hold_alt");
        end
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            push_owner(0);
            check("hold_sole");
        end

        // Asynchronous reset during a grant, then re-grant from ptr 0
        do_reset();
        req = 4'b0010;
        tick();
        push_owner(1);
        check("mid_grant");
        #2;
        rst_n = 1'b0;
        #1;
        push_idle(2'd0);
        check("mid_reset_async");
        rst_n = 1'b1;
        req   = 4'b0110;
        tick();
        push_owner(1);
        check("regrant_ptr0");

`ifdef ARB_LOCK_EN
        // Lock suppresses hold expiry; dropping it hands over at the next edge
        do_reset();
        din  = 4'b0010;
        req  = 4'b0011;
        lock = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            push_owner(0);
            check("lock_hold");
        end
        lock = 1'b0;
        tick();
        push_owner(1);
        check("lock_release");
`endif

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover scoreboard entries=%0d required=0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
